// File: rtl/button_debouncer.sv
// button_debouncer: per-channel push-button debouncer with press/release strobes.
// Each channel runs a 4-state FSM with a saturating stability counter; a level
// change is accepted only after BOUNCE_TICKS consecutive identical samples.
// Optional macro BUTTON_DEBOUNCER_SYNC_EN inserts a 2-flop synchronizer per
// channel ahead of the FSM (adds 2 edges of latency, FSM rules unchanged).
// All outputs except any_pressed are registered; any_pressed is an OR of
// registered levels only, so there is no combinational path from raw.

module button_debouncer #(
  parameter int N            = 2,
  parameter int BOUNCE_TICKS = 50
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw,
  output logic [N-1:0] debounced,
  output logic [N-1:0] pressed,
  output logic [N-1:0] released,
  output logic         any_pressed
);

  // Counter only ever holds 0..BOUNCE_TICKS-1; the +1 keeps BOUNCE_TICKS = 2^k
  // representable without special-casing the width.
  localparam int            CW   = $clog2(BOUNCE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(BOUNCE_TICKS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_LOW        = 2'd0,
    S_MAYBE_HIGH = 2'd1,
    S_HIGH       = 2'd2,
    S_MAYBE_LOW  = 2'd3
  } state_t;

  // Reject configurations where the counter or the FSM rules stop making sense.
  if (BOUNCE_TICKS < 2 || BOUNCE_TICKS > 65536) begin : g_bad_bounce_ticks
    $error("button_debouncer: BOUNCE_TICKS must be in 2..65536");
  end
  if (N < 1) begin : g_bad_n
    $error("button_debouncer: N must be at least 1");
  end

  // Per-channel sample feeding the FSMs.
  logic [N-1:0] sample;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
  logic [N-1:0] sync_meta;
  logic [N-1:0] sync_q;

  // Two-flop synchronizer; both stages clear on reset so a held button still
  // goes through the full debounce after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  assign sample = sync_q;
`else
  // Input is assumed already synchronous to clk.
  assign sample = raw;
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] count;
    logic          level_q;
    logic          press_q;
    logic          release_q;

    // Debounce FSM: strobes default low each cycle so they last exactly one
    // cycle; the level output is updated only on entry to a stable state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= S_LOW;
        count     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state)
          S_LOW: begin
            if (sample[i]) begin
              state <= S_MAYBE_HIGH;
              count <= ONE;
            end else begin
              count <= '0;
            end
          end
          S_MAYBE_HIGH: begin
            if (!sample[i]) begin
              // Bounce: fall back and restart the count from zero.
              state <= S_LOW;
              count <= '0;
            end else if (count == LAST) begin
              state   <= S_HIGH;
              count   <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              count <= count + ONE;
            end
          end
          S_HIGH: begin
            if (!sample[i]) begin
              state <= S_MAYBE_LOW;
              count <= ONE;
            end else begin
              count <= '0;
            end
          end
          S_MAYBE_LOW: begin
            if (sample[i]) begin
              state <= S_HIGH;
              count <= '0;
            end else if (count == LAST) begin
              state     <= S_LOW;
              count     <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              count <= count + ONE;
            end
          end
          default: begin
            state   <= S_LOW;
            count   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign debounced[i] = level_q;
    assign pressed[i]   = press_q;
    assign released[i]  = release_q;

`ifndef SYNTHESIS
    // Counter saturates below BOUNCE_TICKS and the level tracks the FSM decode.
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count <= LAST);
    a_level_decode: assert property (@(posedge clk) disable iff (rst)
      level_q == (state == S_HIGH || state == S_MAYBE_LOW));
`endif
  end

  assign any_pressed = |debounced;

`ifndef SYNTHESIS
  // A channel can never accept a press and a release in the same cycle.
  a_strobe_exclusive: assert property (@(posedge clk) disable iff (rst)
    (pressed & released) == '0);
`endif

endmodule
